// File: rtl/int_request_ctrl_pkg.sv
// rtl/int_request_ctrl_pkg.sv - shared state encoding and sequence-length constants for the interrupt front-end
package int_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        FIRE = 2'd2,
        BUSY = 2'd3
    } int_state_e;

    localparam int INT_NUM_SRC     = 4;
    // Also consumed by the call sequencer so both sides agree on push/jump length.
    localparam int INT_BUSY_CYCLES = 6;

    function automatic int vec_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_request_ctrl_if.sv
// rtl/int_request_ctrl_if.sv - request lines, pipeline qualifiers and trigger/status outputs of the interrupt front-end
interface int_request_ctrl_if #(
    parameter int NUM_SRC = 4,
    parameter int VEC_W   = 2
);
    logic [NUM_SRC-1:0] irq;
    logic               int_en;
    logic               safe_point;
    logic               int_signal;
    logic [VEC_W-1:0]   int_vector;
    logic               int_busy;
    logic [NUM_SRC-1:0] pending;

    modport master (
        output irq, int_en, safe_point,
        input  int_signal, int_vector, int_busy, pending
    );

    modport slave (
        input  irq, int_en, safe_point,
        output int_signal, int_vector, int_busy, pending
    );
endinterface

// File: rtl/int_request_ctrl_edge.sv
// rtl/int_request_ctrl_edge.sv - rising-edge capture of interrupt lines into a pending register
module irq_edge_detect
    import int_pkg::*;
#(
    parameter int NUM_SRC = INT_NUM_SRC,
    parameter int IDX_W   = vec_width(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_i,
    input  logic               clr_i,
    input  logic [IDX_W-1:0]   clr_idx_i,
    output logic [NUM_SRC-1:0] pending_o
);

    logic [NUM_SRC-1:0] irq_prev_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] pending_d;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr_mask;

    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            clr_mask[i] = clr_i && (clr_idx_i == IDX_W'(i));
        end
    end

    // A fresh edge on the bit being serviced is a new request, so set wins.
    assign rise      = irq_i & ~irq_prev_q;
    assign pending_d = (pending_q & ~clr_mask) | rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_prev_q <= '0;
            pending_q  <= '0;
        end else begin
            irq_prev_q <= irq_i;
            pending_q  <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/int_request_ctrl.sv
// rtl/int_request_ctrl.sv - fixed-priority interrupt arbiter that waits for a safe point and blocks while the sequencer runs
module int_request_ctrl
    import int_pkg::*;
#(
    parameter int NUM_SRC     = INT_NUM_SRC,
    parameter int VEC_W       = vec_width(NUM_SRC),
    parameter int BUSY_CYCLES = INT_BUSY_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    int_request_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(BUSY_CYCLES + 1);

    int_state_e         state_q;
    logic [VEC_W-1:0]   vec_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               signal_q;
    logic               busy_q;
    logic [NUM_SRC-1:0] pending;
    logic [VEC_W-1:0]   winner;
    logic               clr;

    irq_edge_detect #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (VEC_W)
    ) u_edge (
        .clk       (clk),
        .rst       (rst),
        .irq_i     (bus.irq),
        .clr_i     (clr),
        .clr_idx_i (vec_q),
        .pending_o (pending)
    );

    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending[i]) winner = VEC_W'(i);
        end
    end

    assign clr = (state_q == ARM) && bus.int_en && bus.safe_point;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            cnt_q    <= '0;
            signal_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            signal_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if ((|pending) && bus.int_en) begin
                        vec_q   <= winner;
                        state_q <= ARM;
                        busy_q  <= 1'b1;
                    end
                end
                ARM: begin
                    // Dropping enable abandons the pick; the request stays pending.
                    if (!bus.int_en) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (bus.safe_point) begin
                        state_q  <= FIRE;
                        signal_q <= 1'b1;
                    end
                end
                FIRE: begin
                    cnt_q   <= CNT_W'(BUSY_CYCLES);
                    state_q <= BUSY;
                end
                BUSY: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.int_signal = signal_q;
    assign bus.int_vector = vec_q;
    assign bus.int_busy   = busy_q;
    assign bus.pending    = pending;

endmodule

// File: doc/int_request_ctrl.md
# int_request_ctrl

Interrupt request front-end for the RISC core. It captures rising edges on external interrupt lines and holds them as pending requests. It picks one pending request by fixed priority, waits for a pipeline safe point, then issues a single-cycle trigger pulse to the interrupt call sequencer. It stays blocked while that sequencer runs its multi-cycle push/jump sequence, so the sequencer never sees a trigger mid-sequence.

## Interface
Parameters:
- NUM_SRC, 4 — number of interrupt source lines (1..16).
- VEC_W, 2 — vector index width; must equal $clog2(NUM_SRC), minimum 1.
- BUSY_CYCLES, 6 — cycles the downstream sequencer needs after the trigger; must be ≥1.

Ports:
- clk  in  1  — single clock; all state changes on posedge.
- rst  in  1  — asynchronous, active-low reset.
- irq  in  NUM_SRC  — interrupt lines, synchronous to clk; a rising edge is a request.
- int_en  in  1  — global interrupt enable.
- safe_point  in  1  — high when the pipeline can accept an interrupt (no stall, no flush in flight).
- int_signal  out  1  — one-cycle trigger to the call sequencer.
- int_vector  out  VEC_W  — index of the serviced source; stable from ARM through BUSY.
- int_busy  out  1  — high whenever state ≠ IDLE.
- pending  out  NUM_SRC  — pending request bits, for debug and status.

## Operation
- Edge detect: irq_prev is registered each cycle. edge[i] = irq[i] & ~irq_prev[i] sets pending[i].
- Priority: lowest index wins. The winning index goes to int_vector.
- FSM states: IDLE, ARM, FIRE, BUSY.
  - IDLE: if any pending bit is set and int_en=1, latch the winner into int_vector and go to ARM. Otherwise stay in IDLE.
  - ARM: if int_en=0, go to IDLE; pending is untouched and the vector is re-picked on the next entry. Else if safe_point=1, go to FIRE and clear pending[int_vector]. Else stay in ARM.
  - FIRE: int_signal=1 for this cycle only. Load counter = BUSY_CYCLES and go to BUSY. int_en is ignored from FIRE onward.
  - BUSY: decrement the counter each cycle. When the counter reaches 1, go to IDLE on the next edge. BUSY therefore lasts exactly BUSY_CYCLES cycles.
- Counter width is $clog2(BUSY_CYCLES+1) and unsigned. It never wraps, because it is only loaded in FIRE.
- Simultaneous set and clear on the same bit: set wins, so the bit stays pending. This is a new request, not the one just serviced.
- New edges arriving during ARM, FIRE or BUSY accumulate in pending. A repeated edge on an already-pending source is merged into the one pending bit.
- Reset (asynchronous, rst=0) forces:
  - state=IDLE
  - pending=0
  - irq_prev=0
  - int_vector=0
  - counter=0
  - int_signal=0
  - int_busy=0
- Reset mid-sequence drops the serviced request and all pending requests.
- After reset release, an irq line already high counts as a rising edge, because irq_prev=0.

## Timing
- Edge k: irq[i] sampled 1 with irq_prev[i]=0. pending[i]=1 after edge k.
- Edge k+1: IDLE→ARM; int_vector valid and int_busy=1.
- Edge k+2, with safe_point=1: ARM→FIRE. int_signal high for the cycle between k+2 and k+3, and pending[i] clears.
- Edge k+3: FIRE→BUSY. int_signal low.
- Edge k+3+BUSY_CYCLES: BUSY→IDLE and int_busy=0.
- Minimum request-to-trigger latency: 2 cycles after pending is set.
- Minimum spacing between triggers: BUSY_CYCLES+3 cycles.
- Each cycle safe_point stays low in ARM adds one cycle of latency. There is no timeout.

## Structure
- Shared package `int_pkg` holds:
  - the state encoding (IDLE=2'd0, ARM=2'd1, FIRE=2'd2, BUSY=2'd3);
  - default NUM_SRC and BUSY_CYCLES;
  - the INT_BUSY_CYCLES constant, so the upstream controller and the call sequencer agree on sequence length.
- One sub-module: `irq_edge_detect`, parameterised by NUM_SRC. It owns irq_prev, the pending register, and the set-wins-over-clear rule. Inputs: a clear strobe and a clear index. Output: pending.
- Priority encoder, FSM and counter live in the top module.

## Test plan
- Single request: NUM_SRC=4, BUSY_CYCLES=6, int_en=1, safe_point=1; pulse irq[2] at edge 10 → int_vector=2 from edge 11, int_signal high in cycle 12–13 only, int_busy falls at edge 19, pending=0.
- Priority and queueing: irq[3] and irq[1] rise on the same edge → first trigger has vector 1. Second trigger has vector 3, issued exactly BUSY_CYCLES+3 cycles after the first.
- Safe-point stall: hold safe_point=0 for 5 cycles in ARM → int_signal is delayed 5 cycles, and the vector stays stable throughout.
- Enable drop: int_en falls while in ARM → return to IDLE with no int_signal and pending unchanged. Re-asserting int_en → normal trigger.
- Set/clear collision: a new edge on irq[0] in the same cycle as the ARM→FIRE clear of source 0 → pending[0]=1 afterwards, and a second trigger with vector 0 follows.
- Async reset during BUSY (counter=3) → all outputs 0 immediately, without waiting for a clock edge. irq[1] held high through reset release → trigger with vector 1 after 3 edges.
